// File: rtl/mdu_if.sv
// Bundle of the signals between the E-stage controller and the multiply/divide unit.
// start is a single-cycle request. It is taken only when busy=0 and req=0; otherwise it is dropped, never queued.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  modport master (
    output start, op, A, B, req,
    input  busy, out, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, A, B, req,
    output busy, out, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu.sv
// MIPS-style multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// The result is computed at accept and held in temp registers; HI/LO change only when the busy window completes.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] temp_hi_q, temp_hi_d;
  logic [31:0] temp_lo_q, temp_lo_d;
  logic        skip_q, skip_d;

  logic               is_md_op;
  logic               accept;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa, sb;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;

  assign is_md_op = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign accept   = bus.start && is_md_op && (state_q == S_IDLE) && !bus.req;

  // Arithmetic datapath; zero divisor and signed overflow are handled explicitly so no X is produced.
  always_comb begin
    sa     = $signed(bus.A);
    sb     = $signed(bus.B);
    prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (bus.B != 32'd0) begin
      quot_u = bus.A / bus.B;
      rem_u  = bus.A % bus.B;
      if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = 32'(sa / sb);
        rem_s  = 32'(sa % sb);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    temp_hi_d = temp_hi_q;
    temp_lo_d = temp_lo_q;
    skip_d    = skip_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          skip_d  = 1'b0;
          case (bus.op)
            OP_MULT:  begin temp_hi_d = prod_s[63:32]; temp_lo_d = prod_s[31:0]; cnt_d = CW'(MULT_CYCLES); end
            OP_MULTU: begin temp_hi_d = prod_u[63:32]; temp_lo_d = prod_u[31:0]; cnt_d = CW'(MULT_CYCLES); end
            OP_DIV:   begin temp_hi_d = rem_s; temp_lo_d = quot_s; cnt_d = CW'(DIV_CYCLES); skip_d = (bus.B == 32'd0); end
            default:  begin temp_hi_d = rem_u; temp_lo_d = quot_u; cnt_d = CW'(DIV_CYCLES); skip_d = (bus.B == 32'd0); end
          endcase
        end else if (!bus.req) begin
          if (bus.op == OP_MTHI) hi_d = bus.A;
          if (bus.op == OP_MTLO) lo_d = bus.A;
        end
      end
      default: begin
        // Last busy cycle: retire the result unless the divisor was zero.
        if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!skip_q) begin
            hi_d = temp_hi_q;
            lo_d = temp_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      temp_hi_q <= 32'd0;
      temp_lo_q <= 32'd0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      temp_hi_q <= temp_hi_d;
      temp_lo_q <= temp_lo_d;
      skip_q    <= skip_d;
    end
  end

  assign bus.busy      = (state_q == S_BUSY);
  assign bus.dbg_state = state_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.out       = (bus.op == OP_MFHI) ? hi_q :
                         (bus.op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply/divide results, busy window length, flush, stall and reset behaviour.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected HI then LO are queued before an operation and popped after it.
  task automatic expect_hilo(input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back(h);
    exp_q.push_back(l);
  endtask

  task automatic check_hilo(input string tag);
    logic [31:0] h, l;
    if (exp_q.size() < 2) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd2);
    end else begin
      h = exp_q.pop_front();
      l = exp_q.pop_front();
      check({tag, "_hi"}, bus.hi, h);
      check({tag, "_lo"}, bus.lo, l);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives a start for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.op = op;
    bus.A  = a;
    @(negedge clk);
    bus.op = 4'd0;
  endtask

  // Counts busy cycles from the current negedge; bounded so a stuck busy ends the wait.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  int nb;
  int nb2;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    bus.req   = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    bus.op = 4'd5;
    #1 check("rst_out_mfhi", bus.out, 32'd0);
    bus.op = 4'd6;
    #1 check("rst_out_mflo", bus.out, 32'd0);
    bus.op = 4'd0;

    // MULT / MULTU
    expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    count_busy(nb);
    check("mult_busy_cycles", 32'(nb), 32'(MC));
    check_hilo("mult");

    expect_hilo(32'h0000_0001, 32'hFFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    count_busy(nb);
    check("multu_busy_cycles", 32'(nb), 32'(MC));
    check_hilo("multu");

    // DIV / DIVU
    expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(nb);
    check("div_busy_cycles", 32'(nb), 32'(DC));
    check_hilo("div_neg");

    expect_hilo(32'd1, 32'd3);
    issue(4'd4, 32'd7, 32'd2);
    count_busy(nb);
    check_hilo("divu");

    expect_hilo(32'h0000_0000, 32'h8000_0000);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(nb);
    check_hilo("div_ovf");

    // Divide by zero keeps HI/LO
    move_to(4'd7, 32'h11);
    move_to(4'd8, 32'h22);
    expect_hilo(32'h11, 32'h22);
    issue(4'd4, 32'd99, 32'd0);
    count_busy(nb);
    check("div0_busy_cycles", 32'(nb), 32'(DC));
    check_hilo("div0");

    // Start, MTHI and req during busy have no effect
    do_reset();
    expect_hilo(32'd0, 32'd12);
    issue(4'd1, 32'd3, 32'd4);
    bus.start = 1'b1;
    bus.op    = 4'd3;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd7;
    bus.A     = 32'h55;
    @(negedge clk);
    bus.op    = 4'd0;
    bus.req   = 1'b1;
    @(negedge clk);
    bus.req   = 1'b0;
    count_busy(nb2);
    check("stall_busy_cycles", 32'(3 + nb2), 32'(MC));
    check_hilo("stall");

    // Flushed start
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd1;
    bus.A     = 32'd5;
    bus.B     = 32'd5;
    bus.req   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.req   = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (7) @(negedge clk);
    expect_hilo(32'd0, 32'd12);
    check_hilo("flush");

    // Non-MD op with start
    issue(4'd5, 32'd1, 32'd1);
    check("nop_start_busy", 32'(bus.busy), 32'd0);

    // Reset mid-divide
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    expect_hilo(32'd0, 32'd0);
    check_hilo("rst_mid");
    repeat (15) @(negedge clk);
    expect_hilo(32'd0, 32'd0);
    check_hilo("rst_mid_late");

    // MFHI / MFLO read path
    move_to(4'd7, 32'hABCD);
    move_to(4'd8, 32'h1234);
    bus.op = 4'd6;
    #1 check("out_mflo", bus.out, 32'h1234);
    bus.op = 4'd5;
    #1 check("out_mfhi", bus.out, 32'hABCD);
    bus.op = 4'd0;
    #1 check("out_none", bus.out, 32'd0);
    bus.op = 4'd9;
    #1 check("out_op9", bus.out, 32'd0);
    bus.op = 4'd0;

    // MTHI/MTLO suppressed by req
    @(negedge clk);
    bus.op  = 4'd7;
    bus.A   = 32'hDEAD;
    bus.req = 1'b1;
    @(negedge clk);
    bus.op  = 4'd0;
    bus.req = 1'b0;
    check("mthi_req_hi", bus.hi, 32'hABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
